// File: rtl/framebuffer_write_queue_if.sv
// Bus between the pixel-write command path, the queue and the RAM arbiter.
// The master side drives write strobes and the grant; the slave side is the queue.
interface framebuffer_write_queue_if #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int PIX_BITS  = 2,
  parameter int ADDR_BITS = 11
);
  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  column;
  logic [PIX_BITS-1:0]  pixel;
  logic [7:0]           data_in;
  logic                 write_enable;
  logic                 access_start;
  logic                 ram_grant;
  logic                 ram_req;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_data;
  logic                 full;
  logic                 overflow;
  logic                 range_error;
  logic [15:0]          write_count;

  modport master (
    output row, column, pixel, data_in, write_enable, access_start, ram_grant,
    input  ram_req, ram_we, ram_addr, ram_data, full, overflow, range_error, write_count
  );

  modport slave (
    input  row, column, pixel, data_in, write_enable, access_start, ram_grant,
    output ram_req, ram_we, ram_addr, ram_data, full, overflow, range_error, write_count
  );
endinterface

// File: rtl/framebuffer_write_queue.sv
// Framebuffer write queue: turns row/column/byte write strobes into linear
// byte addresses, buffers them in a small FIFO and drains them into the
// shared framebuffer RAM whenever the arbiter grants the write port.
module framebuffer_write_queue #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 16,
  parameter int PIXEL_WIDTH     = 64,
  parameter int DEPTH           = 4,
  parameter int ADDR_BITS       = $clog2(PIXEL_HEIGHT*PIXEL_WIDTH*BYTES_PER_PIXEL)
) (
  input logic                    clk,
  input logic                    reset,
  framebuffer_write_queue_if.slave bus
);
  // Coordinate fields are one bit wider than strictly needed so that
  // out-of-range values such as row == PIXEL_HEIGHT can be presented and rejected.
  localparam int ROW_BITS = $clog2(PIXEL_HEIGHT + 1);
  localparam int COL_BITS = $clog2(PIXEL_WIDTH + 1);
  localparam int PIX_BITS = $clog2(BYTES_PER_PIXEL + 1);
  localparam int PTR_BITS = $clog2(DEPTH);

  localparam logic [ROW_BITS-1:0]  LP_HEIGHT = ROW_BITS'(PIXEL_HEIGHT);
  localparam logic [COL_BITS-1:0]  LP_WIDTH  = COL_BITS'(PIXEL_WIDTH);
  localparam logic [PIX_BITS-1:0]  LP_BPP    = PIX_BITS'(BYTES_PER_PIXEL);
  localparam logic [ADDR_BITS:0]   LP_WIDE_W = (ADDR_BITS+1)'(PIXEL_WIDTH);
  localparam logic [ADDR_BITS:0]   LP_WIDE_B = (ADDR_BITS+1)'(BYTES_PER_PIXEL);
  localparam logic [PTR_BITS:0]    LP_DEPTH  = (PTR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0] r_memAddr [DEPTH];
  logic [7:0]           r_memData [DEPTH];
  logic [PTR_BITS-1:0]  r_wrPtr;
  logic [PTR_BITS-1:0]  r_rdPtr;
  logic [PTR_BITS:0]    r_count;
  logic                 r_overflow;
  logic                 r_rangeError;
  logic [15:0]          r_writeCount;

  logic [ADDR_BITS:0]   w_addrWide;
  logic                 w_inRange;
  logic                 w_req;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_dropFull;
  logic                 w_dropRange;

  assign w_addrWide = (((ADDR_BITS+1)'(bus.row) * LP_WIDE_W) + (ADDR_BITS+1)'(bus.column))
                      * LP_WIDE_B + (ADDR_BITS+1)'(bus.pixel);
  assign w_inRange  = (bus.row < LP_HEIGHT) && (bus.column < LP_WIDTH) && (bus.pixel < LP_BPP);

  assign w_req       = (r_count != '0);
  assign w_full      = (r_count == LP_DEPTH);
  assign w_pop       = w_req && bus.ram_grant;
  assign w_push      = bus.write_enable && w_inRange && (!w_full || w_pop);
  assign w_dropFull  = bus.write_enable && w_inRange && w_full && !w_pop;
  assign w_dropRange = bus.write_enable && !w_inRange;

  assign bus.ram_req     = w_req;
  assign bus.ram_we      = w_pop;
  assign bus.ram_addr    = r_memAddr[r_rdPtr];
  assign bus.ram_data    = r_memData[r_rdPtr];
  assign bus.full        = w_full;
  assign bus.overflow    = r_overflow;
  assign bus.range_error = r_rangeError;
  assign bus.write_count = r_writeCount;

  // FIFO storage and pointers; a push in the same cycle as a pop may land in a full queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_memAddr[i] <= '0;
        r_memData[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_memAddr[r_wrPtr] <= w_addrWide[ADDR_BITS-1:0];
        r_memData[r_wrPtr] <= bus.data_in;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_rangeError <= 1'b0;
    end else begin
      if (w_dropFull) begin
        r_overflow <= 1'b1;
      end else if (bus.access_start) begin
        r_overflow <= 1'b0;
      end
      if (w_dropRange) begin
        r_rangeError <= 1'b1;
      end else if (bus.access_start) begin
        r_rangeError <= 1'b0;
      end
    end
  end

  // Count of bytes committed to RAM, wrapping and cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_writeCount <= '0;
    end else if (w_pop) begin
      r_writeCount <= r_writeCount + 16'd1;
    end
  end
endmodule

// File: tb/tb_framebuffer_write_queue.sv
// Directed bench for framebuffer_write_queue with a RAM model and commit log.
module tb_framebuffer_write_queue;
  localparam int ADDR_BITS = 11;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0]           ramModel [0:2047];
  logic [ADDR_BITS-1:0] logAddr [$];
  logic [7:0]           logData [$];

  framebuffer_write_queue_if #(.ROW_BITS(5), .COL_BITS(7), .PIX_BITS(2), .ADDR_BITS(ADDR_BITS)) bus ();

  framebuffer_write_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: record every committed write at the edge it happens.
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      ramModel[bus.ram_addr] <= bus.ram_data;
      logAddr.push_back(bus.ram_addr);
      logData.push_back(bus.ram_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWrite(input int r, input int c, input int p, input logic [7:0] d);
    bus.row          = 5'(r);
    bus.column       = 7'(c);
    bus.pixel        = 2'(p);
    bus.data_in      = d;
    bus.write_enable = 1'b1;
    step();
    bus.write_enable = 1'b0;
  endtask

  task automatic pulseAccessStart();
    bus.access_start = 1'b1;
    step();
    bus.access_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    bus.ram_grant = 1'b1;
    while (bus.ram_req === 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    bus.ram_grant = 1'b0;
    checks++;
    if (bus.ram_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_drain_timeout ram_req=%b required 0", name, bus.ram_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks += 8;
    if (bus.ram_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_req got %b need 0", bus.ram_req); end
    if (bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got %b need 0", bus.ram_we); end
    if (bus.ram_addr !== 11'd0) begin errors++; $display("[TB] FAIL reset_ram_addr got %0d need 0", bus.ram_addr); end
    if (bus.ram_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_ram_data got %h need 00", bus.ram_data); end
    if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b need 0", bus.full); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b need 0", bus.overflow); end
    if (bus.range_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_range_error got %b need 0", bus.range_error); end
    if (bus.write_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_write_count got %0d need 0", bus.write_count); end
  endtask

  task automatic test_address_math();
    logAddr.delete();
    logData.delete();
    bus.ram_grant = 1'b1;
    pushWrite(3, 5, 1, 8'hA5);
    checks += 4;
    if (bus.ram_req !== 1'b1) begin errors++; $display("[TB] FAIL addr_ram_req got %b need 1", bus.ram_req); end
    if (bus.ram_we !== 1'b1) begin errors++; $display("[TB] FAIL addr_ram_we got %b need 1", bus.ram_we); end
    if (bus.ram_addr !== 11'd395) begin errors++; $display("[TB] FAIL addr_ram_addr got %0d need 395", bus.ram_addr); end
    if (bus.ram_data !== 8'hA5) begin errors++; $display("[TB] FAIL addr_ram_data got %h need a5", bus.ram_data); end
    step();
    bus.ram_grant = 1'b0;
    checks += 3;
    if (bus.ram_req !== 1'b0) begin errors++; $display("[TB] FAIL addr_req_after got %b need 0", bus.ram_req); end
    if (bus.write_count !== 16'd1) begin errors++; $display("[TB] FAIL addr_write_count got %0d need 1", bus.write_count); end
    if (logAddr.size() != 1) begin errors++; $display("[TB] FAIL addr_commit_count got %0d need 1", logAddr.size()); end
  endtask

  task automatic test_fill_block();
    logic [7:0] expData [4];
    logAddr.delete();
    logData.delete();
    bus.ram_grant = 1'b0;
    for (int i = 0; i < 4; i++) pushWrite(0, i, 0, 8'h10 + 8'(i));
    checks += 2;
    if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %b need 1", bus.full); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_overflow got %b need 0", bus.overflow); end
    pushWrite(0, 9, 0, 8'hEE);
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow got %b need 1", bus.overflow); end
    if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full_kept got %b need 1", bus.full); end
    drain("fill");
    expData = '{8'h10, 8'h11, 8'h12, 8'h13};
    checks++;
    if (logAddr.size() != 4) begin
      errors++;
      $display("[TB] FAIL fill_commit_count got %0d need 4", logAddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (logData[i] !== expData[i]) begin errors++; $display("[TB] FAIL fill_order_data[%0d] got %h need %h", i, logData[i], expData[i]); end
        if (logAddr[i] !== 11'(2 * i)) begin errors++; $display("[TB] FAIL fill_order_addr[%0d] got %0d need %0d", i, logAddr[i], 2 * i); end
      end
    end
    checks++;
    if (bus.write_count !== 16'd5) begin errors++; $display("[TB] FAIL fill_write_count got %0d need 5", bus.write_count); end
    pulseAccessStart();
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_overflow_clear got %b need 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] expData [5];
    bus.ram_grant = 1'b0;
    for (int i = 0; i < 4; i++) pushWrite(0, 20 + i, 1, 8'h20 + 8'(i));
    logAddr.delete();
    logData.delete();
    bus.ram_grant = 1'b1;
    pushWrite(1, 0, 0, 8'h24);
    bus.ram_grant = 1'b0;
    checks += 2;
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_overflow got %b need 0", bus.overflow); end
    if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_full got %b need 1", bus.full); end
    drain("pushpop");
    expData = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    checks++;
    if (logData.size() != 5) begin
      errors++;
      $display("[TB] FAIL pushpop_commit_count got %0d need 5", logData.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (logData[i] !== expData[i]) begin errors++; $display("[TB] FAIL pushpop_order[%0d] got %h need %h", i, logData[i], expData[i]); end
      end
      checks++;
      if (logAddr[4] !== 11'd128) begin errors++; $display("[TB] FAIL pushpop_new_addr got %0d need 128", logAddr[4]); end
    end
    checks++;
    if (bus.write_count !== 16'd10) begin errors++; $display("[TB] FAIL pushpop_write_count got %0d need 10", bus.write_count); end
  endtask

  task automatic test_range_error();
    bus.ram_grant = 1'b0;
    pushWrite(16, 0, 0, 8'h01);
    checks += 2;
    if (bus.ram_req !== 1'b0) begin errors++; $display("[TB] FAIL range_row_req got %b need 0", bus.ram_req); end
    if (bus.range_error !== 1'b1) begin errors++; $display("[TB] FAIL range_row_flag got %b need 1", bus.range_error); end
    pulseAccessStart();
    checks++;
    if (bus.range_error !== 1'b0) begin errors++; $display("[TB] FAIL range_clear got %b need 0", bus.range_error); end
    pushWrite(0, 64, 0, 8'h02);
    checks++;
    if (bus.range_error !== 1'b1) begin errors++; $display("[TB] FAIL range_col_flag got %b need 1", bus.range_error); end
    pulseAccessStart();
    pushWrite(0, 0, 2, 8'h03);
    checks += 2;
    if (bus.range_error !== 1'b1) begin errors++; $display("[TB] FAIL range_pix_flag got %b need 1", bus.range_error); end
    if (bus.ram_req !== 1'b0) begin errors++; $display("[TB] FAIL range_pix_req got %b need 0", bus.ram_req); end
    pulseAccessStart();
    bus.access_start = 1'b1;
    pushWrite(0, 0, 2, 8'h04);
    bus.access_start = 1'b0;
    checks++;
    if (bus.range_error !== 1'b1) begin errors++; $display("[TB] FAIL range_error_wins got %b need 1", bus.range_error); end
    pulseAccessStart();
    pushWrite(15, 63, 1, 8'h5A);
    checks += 3;
    if (bus.range_error !== 1'b0) begin errors++; $display("[TB] FAIL range_max_flag got %b need 0", bus.range_error); end
    if (bus.ram_req !== 1'b1) begin errors++; $display("[TB] FAIL range_max_req got %b need 1", bus.ram_req); end
    if (bus.ram_addr !== 11'd2047) begin errors++; $display("[TB] FAIL range_max_addr got %0d need 2047", bus.ram_addr); end
    drain("range");
    checks += 2;
    if (ramModel[2047] !== 8'h5A) begin errors++; $display("[TB] FAIL range_max_ram got %h need 5a", ramModel[2047]); end
    if (bus.write_count !== 16'd11) begin errors++; $display("[TB] FAIL range_write_count got %0d need 11", bus.write_count); end
  endtask

  task automatic test_reset_mid_drain();
    bus.ram_grant = 1'b0;
    for (int i = 0; i < 3; i++) pushWrite(5, i, 0, 8'h60 + 8'(i));
    bus.ram_grant = 1'b1;
    step();
    bus.ram_grant = 1'b0;
    step();
    bus.ram_grant = 1'b1;
    reset = 1'b1;
    pushWrite(6, 6, 0, 8'h99);
    reset = 1'b0;
    bus.ram_grant = 1'b0;
    checks += 3;
    if (bus.ram_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req got %b need 0", bus.ram_req); end
    if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_full got %b need 0", bus.full); end
    if (bus.write_count !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_write_count got %0d need 0", bus.write_count); end
    logAddr.delete();
    logData.delete();
    pushWrite(2, 1, 0, 8'h77);
    drain("rstmid");
    checks += 3;
    if (logAddr.size() != 1) begin
      errors++;
      $display("[TB] FAIL rstmid_commit_count got %0d need 1", logAddr.size());
    end else if (logAddr[0] !== 11'd258 || logData[0] !== 8'h77) begin
      errors++;
      $display("[TB] FAIL rstmid_commit got %0d/%h need 258/77", logAddr[0], logData[0]);
    end
    if (ramModel[258] !== 8'h77) begin errors++; $display("[TB] FAIL rstmid_ram got %h need 77", ramModel[258]); end
    if (bus.write_count !== 16'd1) begin errors++; $display("[TB] FAIL rstmid_after_count got %0d need 1", bus.write_count); end
  endtask

  task automatic test_stream();
    logic [7:0] expData [4];
    expData = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < 4; i++) begin
      bus.ram_grant = 1'($urandom_range(0, 1));
      pushWrite(4, i / 2, i % 2, expData[i]);
    end
    for (int n = 0; n < 200 && bus.ram_req === 1'b1; n++) begin
      bus.ram_grant = 1'($urandom_range(0, 1));
      step();
    end
    drain("stream");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ramModel[512 + i] !== expData[i]) begin errors++; $display("[TB] FAIL stream_ram[%0d] got %h need %h", 512 + i, ramModel[512 + i], expData[i]); end
    end
    checks++;
    if (bus.write_count !== 16'd5) begin errors++; $display("[TB] FAIL stream_write_count got %0d need 5", bus.write_count); end
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.row = '0;
    bus.column = '0;
    bus.pixel = '0;
    bus.data_in = '0;
    bus.write_enable = 1'b0;
    bus.access_start = 1'b0;
    bus.ram_grant = 1'b0;
    test_reset();
    test_address_math();
    test_fill_block();
    test_full_push_pop();
    test_range_error();
    test_reset_mid_drain();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_write_queue.md
# framebuffer_write_queue

Downstream stage of `control_cmd_readpixel` and its sibling pixel-writing subcommands. Accepts per-byte write strobes carrying row/column/pixel-byte coordinates plus data, computes the linear framebuffer byte address, and buffers entries in a small FIFO. It then drains the FIFO into the framebuffer write port whenever the RAM arbiter grants access. This decouples the command path from display-readout contention on the shared RAM.

## Interface
Parameters:
- `BYTES_PER_PIXEL`, `params_pkg::BYTES_PER_PIXEL` (2): bytes per pixel.
- `PIXEL_HEIGHT`, `params_pkg::PIXEL_HEIGHT` (16): rows.
- `PIXEL_WIDTH`, `params_pkg::PIXEL_WIDTH` (64): columns.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_BITS`, `$clog2(PIXEL_HEIGHT*PIXEL_WIDTH*BYTES_PER_PIXEL)`: RAM address width (11 at defaults).

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `row` in `calc_pkg::num_row_address_bits(PIXEL_HEIGHT)`: row coordinate.
- `column` in `calc_pkg::num_column_address_bits(PIXEL_WIDTH)`: column coordinate.
- `pixel` in `calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)`: byte within pixel.
- `data_in` in 8: byte to write.
- `write_enable` in 1: one-cycle strobe; coordinates and data valid this cycle.
- `access_start` in 1: one-cycle pulse at start of a new command; clears sticky errors.
- `ram_grant` in 1: arbiter grants the write port this cycle.
- `ram_req` out 1: FIFO non-empty; requests the port.
- `ram_we` out 1: `ram_req & ram_grant`.
- `ram_addr` out `ADDR_BITS`: head-entry address.
- `ram_data` out 8: head-entry data.
- `full` out 1: FIFO holds `DEPTH` entries.
- `overflow` out 1: sticky; a write was dropped because the FIFO was full.
- `range_error` out 1: sticky; a write was dropped because its coordinates were out of range.
- `write_count` out 16: committed RAM writes, wrapping.

## Operation
- Address: `addr = (row*PIXEL_WIDTH + column)*BYTES_PER_PIXEL + pixel`. Compute at `ADDR_BITS+1` width, then truncate to `ADDR_BITS`.
- Range check on `write_enable`: if `row ≥ PIXEL_HEIGHT`, `column ≥ PIXEL_WIDTH`, or `pixel ≥ BYTES_PER_PIXEL`, drop the entry and set `range_error`.
- Push: an in-range `write_enable` writes `{addr, data_in}` at the tail.
- Pop: when `ram_we` is high, the head entry commits to RAM and is removed at that edge, and `write_count` increments.
- Full: a push is accepted only if `!full`, or if a pop occurs in the same cycle. Otherwise drop it and set `overflow`.
- Simultaneous push and pop (any occupancy): count is unchanged, and both pointers advance modulo `DEPTH`.
- Order: entries drain strictly FIFO; no reordering or coalescing, and duplicate addresses are written twice.
- Error clearing: `access_start` clears `overflow` and `range_error` at the next edge. If an error event occurs in the same cycle as `access_start`, the error wins and the flag stays set. `access_start` does not flush the FIFO.
- `write_count` wraps from 16'hFFFF to 0 and is cleared only by reset.
- State is FIFO storage, read/write pointers, an occupancy counter (0..`DEPTH`), two sticky flags, and `write_count`. No further FSM.

## Timing
- Reset (synchronous): at the edge where `reset` is sampled high, flush the FIFO and set all registered state to 0. This applies mid-drain too; a push in the reset cycle is discarded.
- Outputs after reset: `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `full`=0, `overflow`=0, `range_error`=0, `write_count`=0.
- `ram_req`, `full`, `ram_addr` and `ram_data` are driven from registered state only, with no combinational path from `write_enable`.
- Only `ram_we` is combinational, from `ram_req` and `ram_grant`.
- Latency: `write_enable` sampled at edge N → `ram_req`=1 and head valid from after edge N (cycle N+1). With `ram_grant` held high, the earliest commit is at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- `ram_addr` and `ram_data` hold stable while `ram_req`=1 and `ram_grant`=0.
- With the FIFO empty, `ram_addr` and `ram_data` hold the last-read slot contents; these values are don't-care to consumers.

## Test plan
- Address math: `row`=3, `column`=5, `pixel`=1, `data_in`=8'hA5, grant high → one `ram_we` pulse with `ram_addr`=395, `ram_data`=8'hA5, the cycle after the strobe; `write_count`=1.
- Fill and block: grant low, 4 writes → `full`=1. A 5th write sets `overflow`=1. Grant high → exactly 4 commits in push order, then `ram_req`=0.
- Full with simultaneous push and pop: FIFO full and grant high, push → no `overflow`, `full` stays 1, and the new entry emerges 4th.
- Range error: `row`=16 at defaults → no push, `ram_req` stays 0, `range_error`=1. `access_start` → `range_error`=0 next cycle.
- Reset mid-drain: 3 entries queued, grant toggling, `reset` pulsed → next cycle `ram_req`=0, `full`=0, `write_count`=0. A subsequent write commits normally.
- Stream from `control_cmd_readpixel`: a streamed 2-pixel row with random `ram_grant` → RAM model contents equal the expected bytes and `write_count` equals the number of bytes.
